// File: rtl/exmem_pkg.sv
// Shared types and constants for the EX/MEM pipeline stage.
// No logic: control-bit positions, FSM state encoding, default payload layout.
// Backpressure: n/a.
package exmem_pkg;

    // Bit positions inside the control vector.
    localparam int CTRL_BRANCH   = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_ADDERMUX = 5;

    // Default widths used by the default payload layout.
    localparam int DEF_DATA_W = 64;
    localparam int DEF_RD_W   = 5;
    localparam int DEF_CTRL_W = 6;

    // Number of held entries: EMPTY=0, ONE=1 (M only), FULL=2 (M and S).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } exmem_state_e;

    // Payload carried through the stage at the default widths.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] adder_out;
        logic [DEF_DATA_W-1:0] alu_result;
        logic                  zero;
        logic [DEF_DATA_W-1:0] write_data;
        logic [DEF_RD_W-1:0]   rd;
        logic [DEF_CTRL_W-1:0] ctrl;
    } exmem_payload_t;

    // Flattened payload width for arbitrary parameter choices.
    function automatic int payload_w(input int data_w, input int rd_w, input int ctrl_w);
        return 3 * data_w + 1 + rd_w + ctrl_w;
    endfunction

endpackage

// File: rtl/exmem_entry_reg.sv
// One payload register with synchronous load/clear and async active-low reset.
// Latency: 1 cycle from load to q.
// Backpressure: none; the owner decides when to load. Clear beats load.
module exmem_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Hold the entry; clear wins over load so a flush always empties it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exmem_pipe_stage.sv
// EX/MEM stage: main register M drives out_*, skid register S absorbs one beat of backpressure.
// Latency: 1 cycle accept -> out_valid; in_ready decoded from registered state only.
// Backpressure: out_ready low holds M and fills S; in_ready drops when S is full. EXMEM_STATS_EN adds counters.
module exmem_pipe_stage
    import exmem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 6,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_adder_out,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_write_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_adder_out,
    output logic [DATA_W-1:0] out_alu_result,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_write_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] adder_out;
        logic [DATA_W-1:0] alu_result;
        logic              zero;
        logic [DATA_W-1:0] write_data;
        logic [RD_W-1:0]   rd;
        logic [CTRL_W-1:0] ctrl;
    } payload_t;

    localparam int PW = payload_w(DATA_W, RD_W, CTRL_W);

    exmem_state_e st_q, st_d;
    payload_t     in_pl, m_d, m_q, s_q;
    logic         m_load, m_clear, s_load, s_clear;
    logic         accept, consume;

    assign in_pl = '{adder_out:  in_adder_out,
                     alu_result: in_alu_result,
                     zero:       in_zero,
                     write_data: in_write_data,
                     rd:         in_rd,
                     ctrl:       in_ctrl};

    assign in_ready  = (st_q != FULL);
    assign out_valid = (st_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    exmem_entry_reg #(.W(PW)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (m_load),
        .clear (m_clear),
        .d     (m_d),
        .q     (m_q)
    );

    exmem_entry_reg #(.W(PW)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (s_load),
        .clear (s_clear),
        .d     (in_pl),
        .q     (s_q)
    );

    // Occupancy state register; reset discards everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q <= EMPTY;
        end else begin
            st_q <= st_d;
        end
    end

    // Next state and register steering; flush overrides every other event.
    always_comb begin
        st_d    = st_q;
        m_load  = 1'b0;
        m_clear = 1'b0;
        s_load  = 1'b0;
        s_clear = 1'b0;
        m_d     = in_pl;
        if (flush) begin
            st_d    = EMPTY;
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else begin
            case (st_q)
                EMPTY: begin
                    if (accept) begin
                        st_d   = ONE;
                        m_load = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        m_load = 1'b1;
                    end else if (accept) begin
                        st_d   = FULL;
                        s_load = 1'b1;
                    end else if (consume) begin
                        st_d = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        st_d   = ONE;
                        m_load = 1'b1;
                        m_d    = s_q;
                    end
                end
                default: st_d = EMPTY;
            endcase
        end
    end

    // Occupancy reported as a plain count of held entries.
    always_comb begin
        case (st_q)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Control and zero are masked so an empty stage can never issue a store or writeback.
    assign out_adder_out  = m_q.adder_out;
    assign out_alu_result = m_q.alu_result;
    assign out_write_data = m_q.write_data;
    assign out_rd         = m_q.rd;
    assign out_zero       = out_valid & m_q.zero;
    assign out_ctrl       = out_valid ? m_q.ctrl : '0;

`ifdef EXMEM_STATS_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Saturating counters: MEM stall cycles and flushes that actually discarded something.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush && (st_q != EMPTY) && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Bench for exmem_pipe_stage: directed table, hand-written corner sequences, then random traffic vs a queue model.
// Inputs driven 1 time unit after posedge, outputs sampled in the same window (they depend on state only).
// Model: a FIFO of at most two payloads plus plain event counters.
module tb_exmem_pipe_stage;
    import exmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_adder_out = '0;
    logic [63:0] in_alu_result = '0;
    logic        in_zero = 1'b0;
    logic [63:0] in_write_data = '0;
    logic [4:0]  in_rd = '0;
    logic [5:0]  in_ctrl = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_adder_out;
    logic [63:0] out_alu_result;
    logic        out_zero;
    logic [63:0] out_write_data;
    logic [4:0]  out_rd;
    logic [5:0]  out_ctrl;
    logic [1:0]  occupancy;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int n_vec = 0;
    int n_bad = 0;

    exmem_pipe_stage dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_adder_out   (in_adder_out),
        .in_alu_result  (in_alu_result),
        .in_zero        (in_zero),
        .in_write_data  (in_write_data),
        .in_rd          (in_rd),
        .in_ctrl        (in_ctrl),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_adder_out  (out_adder_out),
        .out_alu_result (out_alu_result),
        .out_zero       (out_zero),
        .out_write_data (out_write_data),
        .out_rd         (out_rd),
        .out_ctrl       (out_ctrl),
        .occupancy      (occupancy),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [63:0] alu;
        logic        eov;
        logic [1:0]  eocc;
        logic        eir;
        logic [63:0] ealu;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exmem_payload_t mk(input logic [63:0] alu, input logic [5:0] ctrl);
        exmem_payload_t p;
        p.adder_out  = alu + 64'd100;
        p.alu_result = alu;
        p.zero       = (alu == 64'd0);
        p.write_data = ~alu;
        p.rd         = alu[4:0];
        p.ctrl       = ctrl;
        return p;
    endfunction

    function automatic exmem_payload_t rnd_pl();
        exmem_payload_t p;
        p.adder_out  = {$urandom, $urandom};
        p.alu_result = {$urandom, $urandom};
        p.zero       = 1'($urandom_range(0, 1));
        p.write_data = {$urandom, $urandom};
        p.rd         = 5'($urandom_range(0, 31));
        p.ctrl       = 6'($urandom_range(0, 63));
        return p;
    endfunction

    // Wait for the next edge, then present one cycle of inputs.
    task automatic drive(input logic iv, input logic ordy, input logic fl, input exmem_payload_t p);
        @(posedge clk);
        #1;
        in_valid      = iv;
        out_ready     = ordy;
        flush         = fl;
        in_adder_out  = p.adder_out;
        in_alu_result = p.alu_result;
        in_zero       = p.zero;
        in_write_data = p.write_data;
        in_rd         = p.rd;
        in_ctrl       = p.ctrl;
    endtask

    task automatic chk_counters(input int exp_stall, input int exp_flush);
`ifdef EXMEM_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        chk("flush_cnt", 64'(flush_cnt), 64'(exp_flush));
`else
        chk("stall_cnt_tied", 64'(stall_cnt), 64'(0 * exp_stall));
        chk("flush_cnt_tied", 64'(flush_cnt), 64'(0 * exp_flush));
`endif
    endtask

    exmem_payload_t q[$];
    exmem_payload_t z;
    int m_stall;
    int m_flush;

    initial begin
        z = mk(64'd0, 6'd0);

        // 1: reset, then release
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_out_alu", out_alu_result, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_out_valid", 64'(out_valid), 64'd0);
        chk_counters(0, 0);

        // 2 and 3: streaming and skid fill/drain, expected outputs seen in the same cycle
        tbl[0]  = '{1'b1, 1'b1, 64'h1,  1'b0, 2'd0, 1'b1, 64'h0};
        tbl[1]  = '{1'b1, 1'b1, 64'h2,  1'b1, 2'd1, 1'b1, 64'h1};
        tbl[2]  = '{1'b1, 1'b1, 64'h3,  1'b1, 2'd1, 1'b1, 64'h2};
        tbl[3]  = '{1'b1, 1'b1, 64'h4,  1'b1, 2'd1, 1'b1, 64'h3};
        tbl[4]  = '{1'b0, 1'b1, 64'h0,  1'b1, 2'd1, 1'b1, 64'h4};
        tbl[5]  = '{1'b0, 1'b0, 64'h0,  1'b0, 2'd0, 1'b1, 64'h0};
        tbl[6]  = '{1'b1, 1'b0, 64'h10, 1'b0, 2'd0, 1'b1, 64'h0};
        tbl[7]  = '{1'b1, 1'b0, 64'h20, 1'b1, 2'd1, 1'b1, 64'h10};
        tbl[8]  = '{1'b1, 1'b0, 64'h30, 1'b1, 2'd2, 1'b0, 64'h10};
        tbl[9]  = '{1'b0, 1'b1, 64'h0,  1'b1, 2'd2, 1'b0, 64'h10};
        tbl[10] = '{1'b0, 1'b1, 64'h0,  1'b1, 2'd1, 1'b1, 64'h20};
        tbl[11] = '{1'b0, 1'b0, 64'h0,  1'b0, 2'd0, 1'b1, 64'h0};
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].iv, tbl[i].ordy, 1'b0, mk(tbl[i].alu, 6'd0));
            chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].eov));
            chk($sformatf("tbl%0d_occupancy", i), 64'(occupancy), 64'(tbl[i].eocc));
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].eir));
            if (tbl[i].eov) begin
                chk($sformatf("tbl%0d_out_alu", i), out_alu_result, tbl[i].ealu);
                chk($sformatf("tbl%0d_out_rd", i), 64'(out_rd), 64'(tbl[i].ealu[4:0]));
            end
        end

        // 4: flush while FULL with a store in flight, beat offered in the same cycle
        drive(1'b1, 1'b0, 1'b0, mk(64'h51, 6'h08));
        drive(1'b1, 1'b0, 1'b0, mk(64'h52, 6'h18));
        drive(1'b0, 1'b0, 1'b0, z);
        chk("fl_full_occ", 64'(occupancy), 64'd2);
        chk("fl_full_ctrl", 64'(out_ctrl), 64'h08);
        drive(1'b1, 1'b0, 1'b1, mk(64'h53, 6'h18));
        drive(1'b0, 1'b0, 1'b0, z);
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("fl_out_alu_cleared", out_alu_result, 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        drive(1'b0, 1'b1, 1'b0, z);
        chk("fl_beat_lost", 64'(out_valid), 64'd0);

        // 5: async reset while FULL
        drive(1'b1, 1'b0, 1'b0, mk(64'h61, 6'h10));
        drive(1'b1, 1'b0, 1'b0, mk(64'h62, 6'h10));
        drive(1'b0, 1'b0, 1'b0, z);
        chk("ar_full_occ", 64'(occupancy), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_occ", 64'(occupancy), 64'd0);
        chk("ar_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("ar_out_alu", out_alu_result, 64'd0);
        chk("ar_out_adder", out_adder_out, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // 6: three stall cycles, one effective flush, one flush while empty
        drive(1'b1, 1'b0, 1'b0, mk(64'h71, 6'h01));
        drive(1'b0, 1'b0, 1'b0, z);
        drive(1'b0, 1'b0, 1'b0, z);
        drive(1'b0, 1'b0, 1'b0, z);
        drive(1'b0, 1'b1, 1'b1, z);
        drive(1'b0, 1'b0, 1'b1, z);
        drive(1'b0, 1'b0, 1'b0, z);
        chk_counters(3, 1);

        // Random traffic against the queue model
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        q.delete();
        m_stall = 0;
        m_flush = 0;
        for (int c = 0; c < 3000; c++) begin
            logic iv, ordy, fl;
            logic take, give;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 24) == 0);
            drive(iv, ordy, fl, rnd_pl());
            chk("r_out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("r_in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("r_occupancy", 64'(occupancy), 64'(q.size()));
            if (q.size() > 0) begin
                chk("r_out_alu", out_alu_result, q[0].alu_result);
                chk("r_out_adder", out_adder_out, q[0].adder_out);
                chk("r_out_wdata", out_write_data, q[0].write_data);
                chk("r_out_rd", 64'(out_rd), 64'(q[0].rd));
                chk("r_out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
                chk("r_out_zero", 64'(out_zero), 64'(q[0].zero));
            end else begin
                chk("r_idle_ctrl", 64'(out_ctrl), 64'd0);
                chk("r_idle_zero", 64'(out_zero), 64'd0);
            end
            chk_counters(m_stall, m_flush);

            give = (q.size() > 0) && ordy;
            take = iv && (q.size() < 2);
            if ((q.size() > 0) && !ordy) m_stall++;
            if (fl) begin
                if (q.size() > 0) m_flush++;
                q.delete();
            end else begin
                if (give) void'(q.pop_front());
                if (take) q.push_back(exmem_payload_t'({in_adder_out, in_alu_result, in_zero,
                                                        in_write_data, in_rd, in_ctrl}));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
